dircc_rts_scheduler: RTL and testbench
======================================

Name: dircc_rts_scheduler

Overview:
- Downstream of dircc_rts_handler, one per processing counter.
- Sweeps device addresses and drives the address into the state memory and the RTS handler.
- After the fixed pipeline latency, samples the handler's rts_ready flags.
- For each device with a non-zero flag set, issues one send request to the message sender over a valid/ready handshake.
- Reports sweep completion and quiescence, which feed termination detection.

Parameters:
- ADDRESS_MEM_WIDTH, 32, width of device address and device count.
- RTS_LATENCY, 2, edges from a scan_address update until rts_ready reflects that address (memory read 1 + handler register 1); legal range 1..15.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- enable  in  1  run permission for scanning.
- num_devices  in  ADDRESS_MEM_WIDTH  number of devices on this thread; latched at each sweep start.
- scan_address  out  ADDRESS_MEM_WIDTH  address presented to state memory and RTS handler.
- rts_ready  in  32  output-port flags from the RTS handler for the address RTS_LATENCY edges earlier.
- send_valid  out  1  send request pending.
- send_ready  in  1  sender accepts the request.
- send_address  out  ADDRESS_MEM_WIDTH  device to send from.
- send_ports  out  32  captured rts_ready flags.
- sweep_done  out  1  one-cycle pulse when the last device of a sweep has been processed.
- idle_sweep  out  1  the last complete sweep produced no sends.
- send_count  out  32  total accepted sends.

Behaviour:
- Reset values: scan_address=0, send_valid=0, send_address=0, send_ports=0, sweep_done=0, idle_sweep=0, send_count=0. FSM goes to IDLE, wait counter=0, latched count=0.
- All outputs are registered.
- FSM states: IDLE, WAIT, SEND.
- IDLE:
  - If enable=1 and num_devices!=0: latch num_devices, clear the sweep-had-send flag, go to WAIT with wait counter=0.
  - scan_address is held as-is; it is already 0 after reset or after a wrap.
  - If num_devices=0, stay in IDLE.
- WAIT:
  - Wait counter increments each cycle; scan_address is stable.
  - When counter==RTS_LATENCY, sample rts_ready that cycle. Each address with no RTS therefore costs RTS_LATENCY+1 cycles.
  - rts_ready!=0: capture send_address=scan_address and send_ports=rts_ready, assert send_valid, go to SEND.
  - rts_ready==0: ADVANCE.
- SEND:
  - send_valid, send_address and send_ports are held stable until send_ready=1 is seen with send_valid=1.
  - The cycle after the handshake, send_valid=0.
  - On the handshake: send_count+=1 (wraps modulo 2^32), set the sweep-had-send flag, clear idle_sweep, then ADVANCE.
  - send_valid is never withdrawn once asserted, including when enable drops.
- ADVANCE (an action, not a state):
  - If scan_address==latched_count-1: scan_address=0, sweep_done pulses for 1 cycle, idle_sweep=!sweep-had-send, flag cleared, num_devices re-latched.
  - Otherwise scan_address+=1.
  - Then: enable=0 goes to IDLE; enable=1 goes to WAIT with counter=0.
  - If the re-latched num_devices=0, go to IDLE.
- Deasserting enable never aborts the current address. The FSM finishes WAIT/SEND, advances, then idles. Re-enabling resumes at the held scan_address.
- A num_devices change mid-sweep takes effect only at wrap or on IDLE exit.
- send_ready asserted while send_valid=0 is ignored.
- Asynchronous reset mid-SEND drops send_valid immediately; the request is lost by design.

Decomposition:
- dircc_types_pkg: rts_sched_state_t enum {IDLE, WAIT, SEND} and send_req_t packed struct {address, ports}.
- Single module; no sub-module. The wait counter is 4 bits, sized for RTS_LATENCY at most 15.

Test Plan:
- Single device, no RTS: num_devices=1, enable=1, rts_ready=0 → sweep_done pulses every 3 cycles (RTS_LATENCY=2); idle_sweep=1 after the first sweep; send_count=0.
- Four devices, rts_ready=0x1 only for address 2, send_ready=1 → exactly one handshake per sweep with send_address=2, send_ports=0x1; idle_sweep=0; send_count=N after N sweeps.
- Backpressure: address 1 ready, send_ready low for 5 cycles → send_valid held with stable send_address=1 and send_ports; scan_address stays 1; one increment of send_count on release.
- enable dropped during WAIT on address 3 of 4 → finishes address 3, wraps to 0 with a sweep_done pulse, enters IDLE; on re-enable, scanning restarts at address 0.
- num_devices changed from 4 to 2 mid-sweep → current sweep covers addresses 0..3; following sweeps cover 0..1; num_devices=0 at wrap → IDLE.
- reset_n asserted during SEND → all outputs return to reset values asynchronously; after release with enable=1, scanning resumes from address 0.

Source files
------------

// File: rtl/dircc_types_pkg.sv
// ============================================================================
// Module      : dircc_types_pkg
// Description : Shared types for the dircc RTS scheduler slice. Holds the
//               scheduler FSM state encoding, the send-request record passed
//               to the message sender, and common widths.
// Contents    : rts_sched_state_t - scheduler FSM states (IDLE, WAIT, SEND)
//               send_req_t        - {address, ports} send-request record
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dircc_types_pkg;

  // Width of the per-device output-port flag vector from the RTS handler.
  localparam int RTS_PORTS_WIDTH = 32;

  // Width of the pipeline-wait counter; bounds RTS_LATENCY to 1..15.
  localparam int WAIT_CNT_WIDTH = 4;

  // Address width carried in a send request record.
  localparam int SEND_ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SEND = 2'd2
  } rts_sched_state_t;

  typedef struct packed {
    logic [SEND_ADDR_WIDTH-1:0] address;
    logic [RTS_PORTS_WIDTH-1:0] ports;
  } send_req_t;

endpackage

`default_nettype wire

// File: rtl/dircc_rts_scheduler.sv
// ============================================================================
// Module      : dircc_rts_scheduler
// Description : Sweeps device addresses for one processing counter, waits the
//               fixed state-memory + RTS-handler latency, samples rts_ready and
//               issues one send request per device with pending RTS flags.
//               Reports sweep completion and idle sweeps for termination.
// Ports       : clk, reset_n (async, active-low)
//               enable       - run permission for scanning
//               num_devices  - device count, latched at sweep start
//               scan_address - address to state memory / RTS handler
//               rts_ready    - RTS flags for address RTS_LATENCY edges ago
//               send_valid/send_ready/send_address/send_ports - send request
//               sweep_done   - 1-cycle pulse at end of each sweep
//               idle_sweep   - last complete sweep produced no sends
//               send_count   - total accepted sends (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dircc_rts_scheduler
  import dircc_types_pkg::*;
#(
  parameter int ADDRESS_MEM_WIDTH = 32,
  parameter int RTS_LATENCY       = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic [ADDRESS_MEM_WIDTH-1:0] num_devices,
  output logic [ADDRESS_MEM_WIDTH-1:0] scan_address,
  input  logic [RTS_PORTS_WIDTH-1:0]   rts_ready,
  output logic                         send_valid,
  input  logic                         send_ready,
  output logic [ADDRESS_MEM_WIDTH-1:0] send_address,
  output logic [RTS_PORTS_WIDTH-1:0]   send_ports,
  output logic                         sweep_done,
  output logic                         idle_sweep,
  output logic [31:0]                  send_count
);

  localparam logic [WAIT_CNT_WIDTH-1:0]    LATENCY_CNT = WAIT_CNT_WIDTH'(RTS_LATENCY);
  localparam logic [ADDRESS_MEM_WIDTH-1:0] ADDR_ONE    = ADDRESS_MEM_WIDTH'(1);

  rts_sched_state_t               state_q, state_d;
  logic [WAIT_CNT_WIDTH-1:0]      wait_cnt_q, wait_cnt_d;
  logic [ADDRESS_MEM_WIDTH-1:0]   count_q, count_d;
  logic [ADDRESS_MEM_WIDTH-1:0]   scan_q, scan_d;
  logic                           valid_q, valid_d;
  logic [ADDRESS_MEM_WIDTH-1:0]   saddr_q, saddr_d;
  logic [RTS_PORTS_WIDTH-1:0]     sports_q, sports_d;
  logic                           sweep_done_q, sweep_done_d;
  logic                           idle_sweep_q, idle_sweep_d;
  logic [31:0]                    send_count_q, send_count_d;
  logic                           had_send_q, had_send_d;

  logic                           advance;
  logic                           had_send_now;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      wait_cnt_q   <= '0;
      count_q      <= '0;
      scan_q       <= '0;
      valid_q      <= 1'b0;
      saddr_q      <= '0;
      sports_q     <= '0;
      sweep_done_q <= 1'b0;
      idle_sweep_q <= 1'b0;
      send_count_q <= '0;
      had_send_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      count_q      <= count_d;
      scan_q       <= scan_d;
      valid_q      <= valid_d;
      saddr_q      <= saddr_d;
      sports_q     <= sports_d;
      sweep_done_q <= sweep_done_d;
      idle_sweep_q <= idle_sweep_d;
      send_count_q <= send_count_d;
      had_send_q   <= had_send_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    count_d      = count_q;
    scan_d       = scan_q;
    valid_d      = valid_q;
    saddr_d      = saddr_q;
    sports_d     = sports_q;
    sweep_done_d = 1'b0;
    idle_sweep_d = idle_sweep_q;
    send_count_d = send_count_q;
    had_send_d   = had_send_q;
    advance      = 1'b0;
    had_send_now = had_send_q;

    case (state_q)
      IDLE: begin
        if (enable && (num_devices != '0)) begin
          count_d    = num_devices;
          had_send_d = 1'b0;
          wait_cnt_d = '0;
          state_d    = WAIT;
        end
      end

      WAIT: begin
        if (wait_cnt_q == LATENCY_CNT) begin
          if (rts_ready != '0) begin
            saddr_d  = scan_q;
            sports_d = rts_ready;
            valid_d  = 1'b1;
            state_d  = SEND;
          end else begin
            advance = 1'b1;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      SEND: begin
        // valid is always high in SEND, so send_ready alone marks the handshake
        if (send_ready) begin
          valid_d      = 1'b0;
          send_count_d = send_count_q + 32'd1;
          had_send_now = 1'b1;
          idle_sweep_d = 1'b0;
          advance      = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    if (advance) begin
      wait_cnt_d = '0;
      // ">=" rather than "==": a count re-latched on IDLE exit can be smaller
      // than the held address, and the sweep must still terminate.
      if (scan_q >= (count_q - ADDR_ONE)) begin
        scan_d       = '0;
        sweep_done_d = 1'b1;
        idle_sweep_d = !had_send_now;
        had_send_d   = 1'b0;
        count_d      = num_devices;
        state_d      = (enable && (num_devices != '0)) ? WAIT : IDLE;
      end else begin
        scan_d     = scan_q + ADDR_ONE;
        had_send_d = had_send_now;
        state_d    = enable ? WAIT : IDLE;
      end
    end
  end

  assign scan_address = scan_q;
  assign send_valid   = valid_q;
  assign send_address = saddr_q;
  assign send_ports   = sports_q;
  assign sweep_done   = sweep_done_q;
  assign idle_sweep   = idle_sweep_q;
  assign send_count   = send_count_q;

endmodule

`default_nettype wire

// File: tb/tb_dircc_rts_scheduler.sv
// ============================================================================
// Module      : tb_dircc_rts_scheduler
// Description : Directed self-checking bench for dircc_rts_scheduler with an
//               RTS_LATENCY=2 handler model (two-stage address pipeline that
//               returns rts_flags for rts_addr, zero otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dircc_rts_scheduler;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic [31:0] num_devices;
  logic [31:0] scan_address;
  logic [31:0] rts_ready;
  logic        send_valid;
  logic        send_ready;
  logic [31:0] send_address;
  logic [31:0] send_ports;
  logic        sweep_done;
  logic        idle_sweep;
  logic [31:0] send_count;

  logic [31:0] rts_addr;
  logic [31:0] rts_flags;
  logic [31:0] pipe1, pipe2;

  int checks = 0;
  int errors = 0;

  dircc_rts_scheduler #(
    .ADDRESS_MEM_WIDTH(32),
    .RTS_LATENCY      (2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .num_devices (num_devices),
    .scan_address(scan_address),
    .rts_ready   (rts_ready),
    .send_valid  (send_valid),
    .send_ready  (send_ready),
    .send_address(send_address),
    .send_ports  (send_ports),
    .sweep_done  (sweep_done),
    .idle_sweep  (idle_sweep),
    .send_count  (send_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handler model: memory read stage + handler register stage.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe1 <= '0;
      pipe2 <= '0;
    end else begin
      pipe1 <= scan_address;
      pipe2 <= pipe1;
    end
  end
  assign rts_ready = (pipe2 == rts_addr) ? rts_flags : 32'h0;

  task automatic chk_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_pulse(input int max_cycles, input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < max_cycles && !found; i++) begin
      @(negedge clk);
      if (sweep_done) found = 1'b1;
    end
    chk_value(tag, {63'd0, found}, 64'd1);
  endtask

  task automatic wait_valid(input int max_cycles, input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < max_cycles && !found; i++) begin
      @(negedge clk);
      if (send_valid) found = 1'b1;
    end
    chk_value(tag, {63'd0, found}, 64'd1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int hs;
    int sweeps;
    int pulses;
    int seg;
    logic [31:0] max_scan;
    logic [31:0] exp_max [3];

    exp_max[0] = 32'd3;
    exp_max[1] = 32'd1;
    exp_max[2] = 32'd1;

    reset_n     = 1'b0;
    enable      = 1'b0;
    num_devices = 32'd0;
    send_ready  = 1'b0;
    rts_addr    = 32'd0;
    rts_flags   = 32'd0;

    // ---- Reset state ----
    idle_cycles(2);
    chk_value("rst_scan",   {32'd0, scan_address}, 64'd0);
    chk_value("rst_valid",  {63'd0, send_valid},   64'd0);
    chk_value("rst_saddr",  {32'd0, send_address}, 64'd0);
    chk_value("rst_sports", {32'd0, send_ports},   64'd0);
    chk_value("rst_done",   {63'd0, sweep_done},   64'd0);
    chk_value("rst_idle",   {63'd0, idle_sweep},   64'd0);
    chk_value("rst_count",  {32'd0, send_count},   64'd0);
    reset_n = 1'b1;

    // ---- Single device, no RTS: pulse every 3 cycles ----
    num_devices = 32'd1;
    enable      = 1'b1;
    wait_pulse(10, "t1_first_pulse");
    chk_value("t1_idle_sweep", {63'd0, idle_sweep}, 64'd1);
    @(negedge clk);
    chk_value("t1_gap1", {63'd0, sweep_done}, 64'd0);
    @(negedge clk);
    chk_value("t1_gap2", {63'd0, sweep_done}, 64'd0);
    @(negedge clk);
    chk_value("t1_period", {63'd0, sweep_done}, 64'd1);
    chk_value("t1_count", {32'd0, send_count}, 64'd0);
    enable = 1'b0;
    idle_cycles(10);

    // ---- Four devices, RTS only at address 2 ----
    num_devices = 32'd4;
    rts_addr    = 32'd2;
    rts_flags   = 32'h1;
    send_ready  = 1'b1;
    enable      = 1'b1;
    hs = 0;
    sweeps = 0;
    for (int c = 0; c < 200 && sweeps < 3; c++) begin
      @(negedge clk);
      if (send_valid && send_ready) begin
        hs++;
        chk_value("t2_saddr",  {32'd0, send_address}, 64'd2);
        chk_value("t2_sports", {32'd0, send_ports},   64'h1);
      end
      if (sweep_done) begin
        chk_value("t2_hs_per_sweep", hs, 64'd1);
        chk_value("t2_idle_sweep", {63'd0, idle_sweep}, 64'd0);
        hs = 0;
        sweeps++;
      end
    end
    chk_value("t2_sweeps", sweeps, 64'd3);
    chk_value("t2_count", {32'd0, send_count}, 64'd3);
    // Drop enable in WAIT on address 0: finishes it, parks at address 1.
    enable = 1'b0;
    idle_cycles(10);
    chk_value("t2_park_scan", {32'd0, scan_address}, 64'd1);

    // ---- Backpressure on address 1 ----
    rts_addr   = 32'd1;
    rts_flags  = 32'h5;
    send_ready = 1'b0;
    enable     = 1'b1;
    wait_valid(20, "t3_valid_seen");
    for (int i = 0; i < 5; i++) begin
      chk_value("t3_hold_valid",  {63'd0, send_valid},   64'd1);
      chk_value("t3_hold_saddr",  {32'd0, send_address}, 64'd1);
      chk_value("t3_hold_sports", {32'd0, send_ports},   64'h5);
      chk_value("t3_hold_scan",   {32'd0, scan_address}, 64'd1);
      chk_value("t3_hold_count",  {32'd0, send_count},   64'd3);
      @(negedge clk);
    end
    send_ready = 1'b1;
    @(negedge clk);
    chk_value("t3_rel_valid", {63'd0, send_valid},   64'd0);
    chk_value("t3_rel_count", {32'd0, send_count},   64'd4);
    chk_value("t3_rel_scan",  {32'd0, scan_address}, 64'd2);
    enable = 1'b0;
    idle_cycles(10);
    chk_value("t3_park_scan", {32'd0, scan_address}, 64'd3);

    // ---- Enable dropped during WAIT on address 3 of 4 ----
    rts_flags = 32'h0;
    enable    = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    wait_pulse(10, "t4_wrap_pulse");
    chk_value("t4_wrap_scan", {32'd0, scan_address}, 64'd0);
    chk_value("t4_idle_sweep", {63'd0, idle_sweep}, 64'd1);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sweep_done) pulses++;
    end
    chk_value("t4_idle_pulses", pulses, 64'd0);
    chk_value("t4_idle_scan", {32'd0, scan_address}, 64'd0);
    rts_addr   = 32'd0;
    rts_flags  = 32'h3;
    send_ready = 1'b1;
    enable     = 1'b1;
    wait_valid(10, "t4_resume_valid");
    chk_value("t4_resume_saddr",  {32'd0, send_address}, 64'd0);
    chk_value("t4_resume_sports", {32'd0, send_ports},   64'h3);

    // ---- num_devices 4 -> 2 mid-sweep, then 0 ----
    num_devices = 32'd2;
    max_scan = '0;
    seg = 0;
    for (int c = 0; c < 200 && seg < 3; c++) begin
      @(negedge clk);
      if (sweep_done) begin
        chk_value($sformatf("t5_sweep%0d_max", seg), {32'd0, max_scan}, {32'd0, exp_max[seg]});
        max_scan = '0;
        seg++;
      end else if (scan_address > max_scan) begin
        max_scan = scan_address;
      end
    end
    chk_value("t5_segments", seg, 64'd3);
    chk_value("t5_idle_sweep", {63'd0, idle_sweep}, 64'd0);
    num_devices = 32'd0;
    wait_pulse(20, "t5_final_pulse");
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (sweep_done) pulses++;
    end
    chk_value("t5_zero_pulses", pulses, 64'd0);
    chk_value("t5_zero_scan",  {32'd0, scan_address}, 64'd0);
    chk_value("t5_zero_valid", {63'd0, send_valid},   64'd0);

    // ---- Asynchronous reset during SEND ----
    num_devices = 32'd4;
    rts_addr    = 32'd1;
    rts_flags   = 32'h7;
    send_ready  = 1'b0;
    wait_valid(20, "t6_valid_seen");
    chk_value("t6_pre_saddr", {32'd0, send_address}, 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_value("t6_async_valid",  {63'd0, send_valid},   64'd0);
    chk_value("t6_async_scan",   {32'd0, scan_address}, 64'd0);
    chk_value("t6_async_saddr",  {32'd0, send_address}, 64'd0);
    chk_value("t6_async_sports", {32'd0, send_ports},   64'd0);
    chk_value("t6_async_count",  {32'd0, send_count},   64'd0);
    chk_value("t6_async_done",   {63'd0, sweep_done},   64'd0);
    chk_value("t6_async_idle",   {63'd0, idle_sweep},   64'd0);
    @(negedge clk);
    reset_n    = 1'b1;
    send_ready = 1'b1;
    @(negedge clk);
    chk_value("t6_restart_scan", {32'd0, scan_address}, 64'd0);
    wait_valid(20, "t6_resend_valid");
    chk_value("t6_resend_saddr",  {32'd0, send_address}, 64'd1);
    chk_value("t6_resend_sports", {32'd0, send_ports},   64'h7);
    chk_value("t6_resend_count0", {32'd0, send_count},   64'd0);
    @(negedge clk);
    chk_value("t6_resend_count1", {32'd0, send_count},   64'd1);
    chk_value("t6_resend_drop",   {63'd0, send_valid},   64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
